// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed little-endian byte stream,
// writes it word by word into instruction memory and holds the core in reset until done.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_reset_n,
   output logic              done,
   output logic              error,
   output logic [31:0]       checksum
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEN   = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Capacity in words; one bit wider than the address so a full memory is representable.
   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

   logic [2:0]        state_q,    state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [31:0]       shift_q,    shift_d;
   logic [ADDR_W:0]   n_q,        n_d;
   logic [ADDR_W:0]   wcnt_q,     wcnt_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic [31:0]       wdata_q,    wdata_d;
   logic [31:0]       csum_q,     csum_d;
   logic              error_q,    error_d;

   logic              accept;
   logic              last_byte;
   logic [31:0]       word_asm;
   logic              len_zero;
   logic              len_over;
   logic [ADDR_W:0]   wcnt_inc;

   assign in_ready     = (state_q == S_LEN) || (state_q == S_DATA);
   assign accept       = in_valid && in_ready;
   assign last_byte    = (byte_cnt_q == 2'd3);
   assign word_asm     = {in_data, shift_q[31:8]};
   assign len_zero     = (word_asm == 32'd0);
   assign len_over     = (33'(word_asm) > 33'(CAP));
   assign wcnt_inc     = wcnt_q + 1'b1;

   assign mem_we       = (state_q == S_WRITE);
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign done         = (state_q == S_DONE);
   assign core_reset_n = (state_q == S_DONE);
   assign error        = error_q;
   assign checksum     = csum_q;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      n_d        = n_q;
      wcnt_d     = wcnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      csum_d     = csum_q;
      error_d    = error_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_LEN;
               byte_cnt_d = 2'd0;
               shift_d    = 32'd0;
               wcnt_d     = '0;
               csum_d     = 32'd0;
               error_d    = 1'b0;
            end
         end

         S_LEN: begin
            if (accept) begin
               shift_d    = word_asm;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (last_byte) begin
                  if (len_zero) begin
                     n_d     = '0;
                     state_d = S_DONE;
                  end else if (len_over) begin
                     // Oversized header: flag it but still fill the whole memory.
                     n_d     = CAP;
                     error_d = 1'b1;
                     state_d = S_DATA;
                  end else begin
                     n_d     = word_asm[ADDR_W:0];
                     state_d = S_DATA;
                  end
               end
            end
         end

         S_DATA: begin
            if (accept) begin
               shift_d    = word_asm;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (last_byte) begin
                  addr_d  = wcnt_q[ADDR_W-1:0];
                  wdata_d = word_asm;
                  state_d = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            csum_d  = csum_q ^ wdata_q;
            wcnt_d  = wcnt_inc;
            state_d = (wcnt_inc == n_q) ? S_DONE : S_DATA;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= 2'd0;
         shift_q    <= 32'd0;
         n_q        <= '0;
         wcnt_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         csum_q     <= 32'd0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         n_q        <= n_d;
         wcnt_q     <= wcnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         csum_q     <= csum_d;
         error_q    <= error_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=2): normal load, gapped stream, empty header,
// capacity overflow/boundary, start-ignore and mid-session reset.
module tb_imem_loader;

   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          core_reset_n;
   logic          done;
   logic          error;
   logic [31:0]   checksum;

   imem_loader #(.ADDR_W(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .core_reset_n (core_reset_n),
      .done         (done),
      .error        (error),
      .checksum     (checksum)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          acc_cnt  = 0;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          gap_tab[12] = '{3, 0, 5, 1, 2, 0, 4, 5, 1, 0, 3, 2};
   int          gap_idx = 0;

   // Observe handshakes and write strobes mid-cycle, where everything is stable.
   always @(negedge clk) begin
      if (in_valid && in_ready) acc_cnt++;
      if (mem_we) begin
         wr_addr.push_back(32'(mem_addr));
         wr_data.push_back(mem_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      wr_addr.delete();
      wr_data.delete();
      acc_cnt = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Present one byte after 'gap' idle cycles; returns just after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      logic rdy;
      int   budget;
      in_valid = 1'b0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = b;
      rdy      = 1'b0;
      budget   = 0;
      do begin
         @(negedge clk);
         rdy = in_ready;
         tick();
         budget++;
      end while (!rdy && budget < 64);
      in_valid = 1'b0;
      if (!rdy) check("accept_timeout", 32'(rdy), 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input bit use_gaps);
      int gap;
      for (int i = 0; i < 4; i++) begin
         gap = 0;
         if (use_gaps) begin
            gap = gap_tab[gap_idx % 12];
            gap_idx++;
         end
         send_byte(w[8*i +: 8], gap);
      end
   endtask

   task automatic wait_done();
      int c = 0;
      while (!done && c < 40) begin
         tick();
         c++;
      end
      check("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_core_reset_n", 32'(core_reset_n), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_checksum", checksum, 32'd0);
   endtask

   task automatic check_two_word_result(input string tag);
      check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         check({tag, "_addr0"}, wr_addr[0], 32'd0);
         check({tag, "_data0"}, wr_data[0], 32'h0000_0013);
         check({tag, "_addr1"}, wr_addr[1], 32'd1);
         check({tag, "_data1"}, wr_data[1], 32'h0010_0093);
      end
      check({tag, "_checksum"}, checksum, 32'h0010_0080);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_core_rst_n"}, 32'(core_reset_n), 32'd1);
      check({tag, "_error"}, 32'(error), 32'd0);
      check({tag, "_accepted"}, 32'(acc_cnt), 32'd12);
   endtask

   task automatic run_four_words(input logic [31:0] hdr, input logic exp_err, input string tag);
      logic [31:0] words[4];
      int          acc0;
      words = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
      clear_mon();
      pulse_start();
      send_word(hdr, 1'b0);
      check({tag, "_err_after_hdr"}, 32'(error), 32'(exp_err));
      for (int i = 0; i < 4; i++) send_word(words[i], 1'b0);
      wait_done();
      check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd4);
      if (wr_addr.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check({tag, "_addr"}, wr_addr[i], 32'(i));
            check({tag, "_data"}, wr_data[i], words[i]);
         end
      end
      check({tag, "_checksum"}, checksum, 32'h0000_0004);
      check({tag, "_error"}, 32'(error), 32'(exp_err));
      check({tag, "_core_rst_n"}, 32'(core_reset_n), 32'd1);
      // Excess bytes after completion must not be taken.
      acc0     = acc_cnt;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      repeat (6) tick();
      in_valid = 1'b0;
      check({tag, "_no_excess"}, 32'(acc_cnt), 32'(acc0));
      check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) tick();
      check_reset_outputs();
      reset = 1'b0;

      // Idle loader ignores presented bytes.
      clear_mon();
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (3) tick();
      in_valid = 1'b0;
      check("idle_no_accept", 32'(acc_cnt), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd0);

      // Basic two-word load, with a start pulse during DATA that must be ignored.
      clear_mon();
      pulse_start();
      check("len_core_rst_n", 32'(core_reset_n), 32'd0);
      check("len_in_ready", 32'(in_ready), 32'd1);
      send_word(32'd2, 1'b0);
      send_word(32'h0000_0013, 1'b0);
      check("w0_latency_we", 32'(mem_we), 32'd1);
      check("w0_latency_addr", 32'(mem_addr), 32'd0);
      tick();
      pulse_start();
      check("start_in_data_ignored", 32'(in_ready), 32'd1);
      send_word(32'h0010_0093, 1'b0);
      check("w1_latency_we", 32'(mem_we), 32'd1);
      check("w1_latency_addr", 32'(mem_addr), 32'd1);
      check("w1_latency_data", mem_wdata, 32'h0010_0093);
      check("w1_no_done_yet", 32'(done), 32'd0);
      tick();
      check_two_word_result("basic");

      // Restart from DONE with idle gaps between bytes.
      clear_mon();
      pulse_start();
      check("restart_core_rst_n", 32'(core_reset_n), 32'd0);
      check("restart_done", 32'(done), 32'd0);
      check("restart_checksum", checksum, 32'd0);
      send_word(32'd2, 1'b1);
      send_word(32'h0000_0013, 1'b1);
      send_word(32'h0010_0093, 1'b1);
      wait_done();
      check_two_word_result("gaps");

      // Empty program.
      clear_mon();
      pulse_start();
      send_word(32'd0, 1'b0);
      check("zero_done", 32'(done), 32'd1);
      check("zero_core_rst_n", 32'(core_reset_n), 32'd1);
      check("zero_nwr", 32'(wr_addr.size()), 32'd0);
      check("zero_checksum", checksum, 32'd0);

      // Header over capacity, then exactly at capacity.
      run_four_words(32'd5, 1'b1, "over");
      run_four_words(32'd4, 1'b0, "cap");

      // Reset in the middle of the second word, then a clean reload.
      clear_mon();
      pulse_start();
      send_word(32'd2, 1'b0);
      send_word(32'h0000_0013, 1'b0);
      send_byte(8'h93, 0);
      send_byte(8'h00, 0);
      reset = 1'b1;
      #1;
      check_reset_outputs();
      tick();
      reset = 1'b0;
      repeat (3) tick();
      check("post_rst_idle_ready", 32'(in_ready), 32'd0);
      check("post_rst_idle_done", 32'(done), 32'd0);
      clear_mon();
      pulse_start();
      send_word(32'd2, 1'b0);
      send_word(32'h0000_0013, 1'b0);
      send_word(32'h0010_0093, 1'b0);
      wait_done();
      check_two_word_result("reload");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, word-address width of the instruction memory write port (capacity 2^ADDR_W words).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle pulse; begins a load session from IDLE or DONE.
REQ-005 Port: in_data  input  8  program byte stream.
REQ-006 Port: in_valid  input  1  in_data holds a valid byte.
REQ-007 Port: in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid and in_ready are both 1.
REQ-008 Port: mem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-009 Port: mem_addr  output  ADDR_W  word address of the write.
REQ-010 Port: mem_wdata  output  32  word written.
REQ-011 Port: core_reset_n  output  1  active-low reset to the core; low while loading.
REQ-012 Port: done  output  1  load complete, high until next start or reset.
REQ-013 Port: error  output  1  header word count exceeded capacity; sticky until next start or reset.
REQ-014 Port: checksum  output  32  XOR of all words written in the current session.

Function
REQ-015 States SHALL be IDLE, LEN, DATA, WRITE, DONE.
REQ-016 IDLE: in_ready=0, core_reset_n=0; start -> LEN, clearing byte counter, word counter, checksum, error, done.
REQ-017 LEN: in_ready=1; four accepted bytes form word count N, little-endian (first byte = bits 7:0).
REQ-018 After the 4th LEN byte: N=0 -> DONE; N>2^ADDR_W -> error=1, N clamped to 2^ADDR_W, -> DATA; else -> DATA.
REQ-019 DATA: in_ready=1; four accepted bytes assemble one word, little-endian; after the 4th byte -> WRITE on the next edge.
REQ-020 WRITE: exactly one cycle; in_ready=0, mem_we=1, mem_addr=word counter, mem_wdata=assembled word; checksum ^= word; word counter +1.
REQ-021 From WRITE: words written == N -> DONE, else -> DATA.
REQ-022 Accepted-byte-to-write latency: mem_we asserts the cycle after the edge that accepts the word's 4th byte.
REQ-023 mem_we SHALL be 0 in every state except WRITE; mem_addr/mem_wdata are don't-care when mem_we=0 but SHALL hold last values (no X).
REQ-024 Bytes with in_valid=0 or presented while in_ready=0 SHALL NOT be consumed; idle gaps of any length between bytes are legal.
REQ-025 DONE: done=1, core_reset_n=1, in_ready=0; start -> LEN (new session; core_reset_n=0 again the cycle after start is sampled).
REQ-026 start while in LEN, DATA or WRITE SHALL be ignored.
REQ-027 core_reset_n SHALL be 1 only in DONE; it rises on the same edge done rises.
REQ-028 Word counter SHALL be ADDR_W+1 bits so N=2^ADDR_W completes without wrap; mem_addr uses low ADDR_W bits.
REQ-029 Excess bytes after DONE SHALL not be accepted (in_ready=0).

Reset
REQ-030 reset=1 at any time, including mid-session, SHALL asynchronously force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_reset_n=0, done=0, error=0, checksum=0, all counters 0.
REQ-031 After reset deassertion the loader SHALL stay in IDLE until start; a partially assembled word SHALL be discarded.

Verification
REQ-032 start; bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 -> writes addr0=0x00000013, addr1=0x00100093; checksum=0x00100080; done=1, core_reset_n=1.
REQ-033 Same stream with random in_valid gaps of 0-5 cycles -> identical writes, addresses, checksum; no byte dropped or duplicated.
REQ-034 start; header 00 00 00 00 -> no mem_we, DONE on the edge after the 4th header byte, core_reset_n=1.
REQ-035 ADDR_W=2; header 05 00 00 00 and 5 words -> error=1, exactly 4 writes to addr 0..3, done=1, 5th word's bytes not accepted.
REQ-036 Assert reset after 6 data bytes of a 2-word load -> all outputs at reset values immediately; new start reloads from addr0 correctly.
REQ-037 start asserted during DATA -> ignored; start in DONE -> core_reset_n falls, new session loads.
